// File: rtl/mul35_pkg.sv
// rtl/mul35_pkg.sv - shared widths, types and partial-product combine for the 35x35 multiplier
// No ports: imported by mul35_part and mul35_top.
package mul35_pkg;

    localparam int A_W  = 35;
    localparam int B_W  = 35;
    localparam int P_W  = A_W + B_W;
    localparam int LO_W = 18;
    localparam int HI_W = 17;
    localparam int PP_W = 2 * LO_W;

    typedef logic [A_W-1:0]  operand_t;
    typedef logic [P_W-1:0]  product_t;
    typedef logic [PP_W-1:0] pp_t;

    // Recombine the four partial products into the full product.
    // Both cross terms are added before the shift. Every term is widened to
    // the full product width first, so no carry out of the 18/36-bit
    // boundaries can be lost.
    function automatic product_t pp_combine(
        input pp_t p_ll,
        input pp_t p_lh,
        input pp_t p_hl,
        input pp_t p_hh
    );
        product_t mid;
        mid = product_t'(p_lh) + product_t'(p_hl);
        return product_t'(p_ll) + (mid << LO_W) + (product_t'(p_hh) << (2 * LO_W));
    endfunction

endpackage

// File: rtl/mul35_part.sv
// rtl/mul35_part.sv - unsigned 18x18 -> 36-bit combinational partial-product multiplier
// Ports:
//   a_in  : 18-bit unsigned operand (narrower operands zero-extended by the caller)
//   b_in  : 18-bit unsigned operand
//   p_out : 36-bit unsigned product, combinational
module mul35_part
    import mul35_pkg::*;
(
    input  logic [LO_W-1:0] a_in,
    input  logic [LO_W-1:0] b_in,
    output pp_t             p_out
);

    // An 18x18 product sized to fit a single DSP multiplier.
    assign p_out = pp_t'(a_in) * pp_t'(b_in);

endmodule

// File: rtl/mul35_top.sv
// rtl/mul35_top.sv - unsigned 35x35 -> 70-bit multiplier from four DSP-sized partial products
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous, active-high; clears every register
//   MUL_aa_a0 : operand A, 35-bit unsigned
//   MUL_bb_a0 : operand B, 35-bit unsigned
//   MUL_mm_a6 : registered 70-bit product A*B
// Build option MUL35_PIPE_EN: adds registers on the operands and on the
// partial products (latency 3). Undefined: one output register (latency 1).
module mul35_top
    import mul35_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic [A_W-1:0] MUL_aa_a0,
    input  logic [B_W-1:0] MUL_bb_a0,
    output logic [P_W-1:0] MUL_mm_a6
);

    // Operands as seen by the partial-product multipliers.
    operand_t a_op;
    operand_t b_op;

    // Outputs of the four partial-product multipliers.
    pp_t pp_ll;
    pp_t pp_lh;
    pp_t pp_hl;
    pp_t pp_hh;

    product_t prod_d;
    product_t prod_q;

`ifdef MUL35_PIPE_EN
    operand_t a_d;
    operand_t a_q;
    operand_t b_d;
    operand_t b_q;
    pp_t      pp_ll_d;
    pp_t      pp_ll_q;
    pp_t      pp_lh_d;
    pp_t      pp_lh_q;
    pp_t      pp_hl_d;
    pp_t      pp_hl_q;
    pp_t      pp_hh_d;
    pp_t      pp_hh_q;

    always_comb begin
        a_d     = MUL_aa_a0;
        b_d     = MUL_bb_a0;
        a_op    = a_q;
        b_op    = b_q;
        pp_ll_d = pp_ll;
        pp_lh_d = pp_lh;
        pp_hl_d = pp_hl;
        pp_hh_d = pp_hh;
        prod_d  = pp_combine(pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            pp_ll_q <= '0;
            pp_lh_q <= '0;
            pp_hl_q <= '0;
            pp_hh_q <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            pp_ll_q <= pp_ll_d;
            pp_lh_q <= pp_lh_d;
            pp_hl_q <= pp_hl_d;
            pp_hh_q <= pp_hh_d;
        end
    end
`else
    always_comb begin
        a_op   = MUL_aa_a0;
        b_op   = MUL_bb_a0;
        prod_d = pp_combine(pp_ll, pp_lh, pp_hl, pp_hh);
    end
`endif

    // The 17-bit high halves get a zero MSB so that every multiplier is a
    // uniform unsigned 18x18 multiplier.
    mul35_part u_part_ll (
        .a_in  (a_op[LO_W-1:0]),
        .b_in  (b_op[LO_W-1:0]),
        .p_out (pp_ll)
    );

    mul35_part u_part_lh (
        .a_in  (a_op[LO_W-1:0]),
        .b_in  ({1'b0, b_op[LO_W+HI_W-1:LO_W]}),
        .p_out (pp_lh)
    );

    mul35_part u_part_hl (
        .a_in  ({1'b0, a_op[LO_W+HI_W-1:LO_W]}),
        .b_in  (b_op[LO_W-1:0]),
        .p_out (pp_hl)
    );

    mul35_part u_part_hh (
        .a_in  ({1'b0, a_op[LO_W+HI_W-1:LO_W]}),
        .b_in  ({1'b0, b_op[LO_W+HI_W-1:LO_W]}),
        .p_out (pp_hh)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q <= '0;
        end else begin
            prod_q <= prod_d;
        end
    end

    assign MUL_mm_a6 = prod_q;

endmodule

// File: tb/tb_mul35_top.sv
// tb/tb_mul35_top.sv - scoreboard bench for mul35_top with a plain-arithmetic reference model
module tb_mul35_top;

`ifdef MUL35_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        reset;
    logic [34:0] a_in;
    logic [34:0] b_in;
    logic [69:0] mm;

    typedef struct {
        logic [69:0] exp;
        int          due;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   nid    = 0;

    mul35_top dut (
        .clk       (clk),
        .reset     (reset),
        .MUL_aa_a0 (a_in),
        .MUL_bb_a0 (b_in),
        .MUL_mm_a6 (mm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [69:0] ref_mul(input logic [34:0] a, input logic [34:0] b);
        logic [69:0] wa;
        logic [69:0] wb;
        wa = {35'd0, a};
        wb = {35'd0, b};
        return wa * wb;
    endfunction

    // Monitor: after each rising edge, compare every expectation that is due now.
    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks = checks + 1;
            if (mm !== e.exp || e.due != cyc) begin
                errors = errors + 1;
                $display("FAIL vec%0d cycle %0d product got %h expected %h (due %0d)",
                         e.id, cyc, mm, e.exp, e.due);
            end
        end
    end

    task automatic chk_now(input string name, input logic [69:0] exp);
        checks = checks + 1;
        if (mm !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %h expected %h", name, mm, exp);
        end
    endtask

    task automatic issue_exp(input logic [34:0] a, input logic [34:0] b, input logic [69:0] exp);
        exp_t e;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        e.exp = exp;
        e.due = cyc + LAT;
        e.id  = nid;
        nid   = nid + 1;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [34:0] a, input logic [34:0] b);
        issue_exp(a, b, ref_mul(a, b));
    endtask

    // Release reset just after a falling edge; the output must stay zero for
    // the edges it takes the first new operands to reach it.
    task automatic release_reset();
        exp_t e;
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_now("zero_after_release", 70'd0);
        for (int k = 1; k <= LAT; k++) begin
            e.exp = 70'd0;
            e.due = cyc + k;
            e.id  = nid;
            nid   = nid + 1;
            sb.push_back(e);
        end
    endtask

    function automatic logic [34:0] rand_op();
        logic [63:0] r;
        logic [34:0] v;
        int          mode;
        r    = {$urandom(), $urandom()};
        mode = $urandom_range(0, 4);
        case (mode)
            0:       v = 35'h7FFFFFFFF;
            1:       v = 35'd1 << $urandom_range(0, 34);
            2:       v = (35'd1 << $urandom_range(1, 34)) - 35'd1;
            default: v = r[34:0];
        endcase
        return v;
    endfunction

    initial begin
        int wait_cyc;
        reset = 1'b1;
        a_in  = '0;
        b_in  = '0;
        #1;
        chk_now("reset_async", 70'd0);
        @(posedge clk);
        #2;
        chk_now("reset_held_over_edge", 70'd0);
        release_reset();

        // Directed vectors, issued back to back.
        issue_exp(35'h0005ABCD, 35'h0007ADEF, 70'h2B8CFFED63);
        issue_exp(35'h7FFFFFFFF, 35'h7FFFFFFFF, 70'h3FFFFFFFF000000001);
        issue_exp(35'h0, 35'h7FFFFFFFF, 70'h0);
        issue_exp(35'h1, 35'h123456789, 70'h123456789);
        issue_exp(35'h400000000, 35'h2, 70'h800000000);
        issue_exp(35'h3FFFF, 35'h40000, 70'hFFFFC0000);
        issue_exp(35'h40000, 35'h3FFFF, 70'hFFFFC0000);

        // Random stream, a new pair every cycle.
        for (int i = 0; i < 40; i++) begin
            issue(rand_op(), rand_op());
        end

        // Reset asserted between edges while products are in flight.
        @(posedge clk);
        #3;
        reset = 1'b1;
        a_in  = '0;
        b_in  = '0;
        #1;
        chk_now("reset_mid_stream", 70'd0);
        sb.delete();
        @(negedge clk);
        @(posedge clk);
        #2;
        chk_now("reset_mid_held", 70'd0);
        release_reset();

        issue_exp(35'h0005ABCD, 35'h0007ADEF, 70'h2B8CFFED63);
        for (int i = 0; i < 20; i++) begin
            issue(rand_op(), rand_op());
        end

        // Drain the scoreboard within a bounded number of cycles.
        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < LAT + 10) begin
            @(negedge clk);
            wait_cyc = wait_cyc + 1;
        end
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain pending %0d expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul35_top.md
Name: mul35_top

Overview:
- Unsigned 35x35-bit multiplier producing a full 70-bit product.
- Top-level arithmetic block of the FPGA multiplier test design.
- Inputs are combinational. The product is registered, so it is valid one clock after the operands are applied.
- Built from four DSP-style partial products, 18x18 or smaller.

Parameters:
- A_W, 35, operand A width (fixed; the split below assumes 35)
- B_W, 35, operand B width (fixed)
- P_W, 70, product width = A_W + B_W

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- MUL_aa_a0  input  35  operand A, unsigned
- MUL_bb_a0  input  35  operand B, unsigned
- MUL_mm_a6  output  70  product A*B, unsigned, registered

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high.
  - While reset=1, MUL_mm_a6 = 0 immediately, independent of clk.
  - On reset deassertion, the output stays 0 until the next rising clk edge.
- Arithmetic:
  - MUL_mm_a6 = zero-extended MUL_aa_a0 * MUL_bb_a0. Full 70-bit result, no truncation, no overflow possible.
  - Split each operand into lo = bits[17:0] (18 bits) and hi = bits[34:18] (17 bits).
  - Partial products: p_ll = alo*blo, p_lh = alo*bhi, p_hl = ahi*blo, p_hh = ahi*bhi.
  - Sum: product = p_ll + ((p_lh + p_hl) << 18) + (p_hh << 36). Every intermediate is 70 bits wide.
- Latency and timing:
  - Default latency is 1 cycle. Operands present before rising edge N give their product on MUL_mm_a6 after edge N, held until edge N+1.
  - Full throughput: a new operand pair is accepted every cycle. No handshake, no valid signals.
- Edge cases:
  - X or undriven inputs before first use give an undefined product. No requirement beyond reset behaviour.
  - Reset asserted mid-stream clears the output, and every internal pipeline register when present. In-flight products are discarded.
  - Operands changing every cycle each produce their own product, in order.

Optional Feature:
- Macro: MUL35_PIPE_EN.
- Defined:
  - Operands are registered at the input.
  - Partial products are registered.
  - The shifted sum is registered at the output.
  - Total latency is 3 cycles, throughput still 1 per cycle.
  - All pipeline registers reset asynchronously to 0.
- Undefined: the default single-register design, latency 1.
- Arithmetic result is identical in both builds.

Decomposition:
- Package mul35_pkg holds:
  - localparams A_W=35, B_W=35, P_W=70, LO_W=18, HI_W=17;
  - typedefs operand_t (logic [34:0]), product_t (logic [69:0]), pp_t (logic [35:0]).
- Sub-module mul35_part: unsigned 18x18 to 36-bit combinational multiplier.
  - Inputs are zero-extended where narrower.
  - Instantiated four times, once per partial product.
  - Maps to one DSP slice each.

Test Plan:
- Directed product: reset 1 for 10 ns then 0; apply A=0x5ABCD, B=0x7ADEF -> after one rising edge MUL_mm_a6 = 0x2B8CFFED63.
- Maximum operands: A=B=0x7FFFFFFFF -> MUL_mm_a6 = 0x3FFFFFFFF000000001 (checks carries across the 18/36-bit boundaries).
- Identity and zero:
  - A=0, B=0x7FFFFFFFF -> 0.
  - A=1, B=0x123456789 -> 0x123456789.
- Cross-split carry: A=0x400000000 (2^34), B=2 -> 0x800000000. A=0x3FFFF, B=0x40000 -> 0xFFFFC0000.
- Back-to-back: change operands every cycle for 3 vectors -> each product appears exactly 1 cycle later (3 cycles with MUL35_PIPE_EN), in order.
- Async reset mid-stream: assert reset between clock edges -> MUL_mm_a6 = 0 immediately; after release, first valid product appears 1 edge after the new operands.
